mem_port_arbiter: RTL and testbench

- Shares one core-side memory port (req/gnt/rvalid protocol) between the core's instruction-fetch and data (LSU) request ports.
- Arbitrates requests, holds each request stable until it is granted, and tracks in-flight transactions in order. Read responses are routed back to the issuing requester.
- Sits between the core and the debug/memory address mux, so a single-ported memory subsystem can serve both streams.

---
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between instruction-fetch and data ports.
// Ports: clk/rst (sync, active-high); instr_* fetch port (req/gnt/rvalid/addr/rdata);
// data_* LSU port (req/gnt/rvalid/we/be/addr/wdata/rdata); mem_* shared port towards memory;
// idle_o high when nothing is outstanding and no request is locked.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        idle_o
);
  localparam logic [1:0] LAST = 2'(MAX_OUTSTANDING - 1);
  localparam logic [2:0] MAX = 3'(MAX_OUTSTANDING);
  // owner/last encoding: 0 = instruction, 1 = data
  logic       locked_q, locked_d, owner_q, owner_d, last_q, last_d;
  logic [2:0] count_q, count_d;
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [3:0] fifo_q, fifo_d;
  logic       sel, owner, sel_req, push, pop, empty, head;
  always_comb begin
    sel = (data_req_i & instr_req_i) ? ((DATA_PRIO != 0) ? 1'b1 : ~last_q) : data_req_i;
    owner = locked_q ? owner_q : sel;
    sel_req = owner ? data_req_i : instr_req_i;
    empty = count_q == 3'd0;
    // a locked request stays asserted; count only rises on grant so it never exceeds MAX
    mem_req_o = ~rst & (locked_q | (sel_req & (count_q < MAX)));
    push = mem_req_o & mem_gnt_i;
    pop = ~rst & mem_rvalid_i & ~empty;
    head = fifo_q[rd_q];
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = owner;
    wr_d = push ? ((wr_q == LAST) ? 2'd0 : wr_q + 2'd1) : wr_q;
    rd_d = pop ? ((rd_q == LAST) ? 2'd0 : rd_q + 2'd1) : rd_q;
    count_d = count_q + 3'(push) - 3'(pop);
    locked_d = locked_q ? ~mem_gnt_i : (mem_req_o & ~mem_gnt_i);
    owner_d = owner;
    last_d = push ? owner : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
      owner_q <= 1'b0;
      last_q <= 1'b0;
      count_q <= 3'd0;
      wr_q <= 2'd0;
      rd_q <= 2'd0;
      fifo_q <= 4'd0;
    end else begin
      locked_q <= locked_d;
      owner_q <= owner_d;
      last_q <= last_d;
      count_q <= count_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fifo_q <= fifo_d;
    end
  end
  assign instr_gnt_o = push & ~owner;
  assign data_gnt_o = push & owner;
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o = pop & head;
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;
  assign mem_we_o = owner & data_we_i;
  assign mem_be_o = owner ? data_be_i : 4'hF;
  assign mem_addr_o = owner ? data_addr_i : instr_addr_i;
  assign mem_wdata_o = owner ? data_wdata_i : 32'd0;
  assign idle_o = rst | (empty & ~locked_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of a fixed-priority and a round-robin arbiter instance.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic instr_req = 0, data_req = 0, data_we = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [3:0] data_be = 0;
  logic [31:0] instr_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic p_igt, p_irv, p_dgt, p_drv, p_req, p_we, p_idle;
  logic r_igt, r_irv, r_dgt, r_drv, r_req, r_we, r_idle;
  logic [3:0] p_be, r_be;
  logic [31:0] p_ird, p_drd, p_addr, p_wd, r_ird, r_drd, r_addr, r_wd;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(1)) u_p (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_gnt_o(p_igt), .instr_rvalid_o(p_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(p_ird),
    .data_req_i(data_req), .data_gnt_o(p_dgt), .data_rvalid_o(p_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(p_drd),
    .mem_req_o(p_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(p_we), .mem_be_o(p_be), .mem_addr_o(p_addr), .mem_wdata_o(p_wd),
    .mem_rdata_i(mem_rdata), .idle_o(p_idle));

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIO(0)) u_r (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_gnt_o(r_igt), .instr_rvalid_o(r_irv),
    .instr_addr_i(instr_addr), .instr_rdata_o(r_ird),
    .data_req_i(data_req), .data_gnt_o(r_dgt), .data_rvalid_o(r_drv),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(r_drd),
    .mem_req_o(r_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(r_we), .mem_be_o(r_be), .mem_addr_o(r_addr), .mem_wdata_o(r_wd),
    .mem_rdata_i(mem_rdata), .idle_o(r_idle));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1-2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_we = 0; data_be = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    // reset: outputs suppressed even with active inputs
    instr_req = 1; mem_gnt = 1; mem_rvalid = 1;
    tick(); #1;
    chk("rst_mem_req", p_req, 0);
    chk("rst_instr_gnt", p_igt, 0);
    chk("rst_instr_rvalid", p_irv, 0);
    chk("rst_data_rvalid", p_drv, 0);
    chk("rst_idle", p_idle, 1);
    do_reset(); #1;
    chk("post_rst_idle", p_idle, 1);

    // single instruction fetch
    instr_req = 1; instr_addr = 32'h1000_0040; mem_gnt = 1; #1;
    chk("if_gnt", p_igt, 1);
    chk("if_addr", p_addr, 32'h1000_0040);
    chk("if_be", p_be, 4'hF);
    chk("if_we", p_we, 0);
    chk("if_wdata", p_wd, 0);
    tick(); instr_req = 0; mem_gnt = 0; #1;
    chk("if_busy", p_idle, 0);
    tick(); mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
    chk("if_rvalid", p_irv, 1);
    chk("if_rdata", p_ird, 32'h13);
    chk("if_d_rvalid", p_drv, 0);
    tick(); mem_rvalid = 0; #1;
    chk("if_idle", p_idle, 1);

    // contention, fixed data priority
    do_reset();
    instr_req = 1; data_req = 1; data_we = 1; data_be = 4'h3;
    data_addr = 32'h1000_0100; data_wdata = 32'hDEAD_BEEF; mem_gnt = 1; #1;
    chk("pr_dgnt", p_dgt, 1);
    chk("pr_ignt0", p_igt, 0);
    chk("pr_we", p_we, 1);
    chk("pr_be", p_be, 4'h3);
    chk("pr_addr", p_addr, 32'h1000_0100);
    chk("pr_wdata", p_wd, 32'hDEAD_BEEF);
    tick(); data_req = 0; #1;
    chk("pr_ignt", p_igt, 1);
    chk("pr_iaddr", p_addr, 32'h1000_0040);
    tick(); instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_0001; #1;
    chk("pr_rsp1_d", p_drv, 1);
    chk("pr_rsp1_i", p_irv, 0);
    chk("pr_rsp1_data", p_drd, 32'hAAAA_0001);
    tick(); mem_rdata = 32'hBBBB_0002; #1;
    chk("pr_rsp2_i", p_irv, 1);
    chk("pr_rsp2_d", p_drv, 0);
    tick(); mem_rvalid = 0; #1;
    chk("pr_idle", p_idle, 1);

    // round-robin: grants alternate D,I,D,I; each response one cycle after its grant
    do_reset();
    instr_req = 1; data_req = 1; data_we = 0; mem_gnt = 1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = (k > 0); #1;
      chk($sformatf("rr_dgnt%0d", k), r_dgt, (k % 2 == 0));
      chk($sformatf("rr_ignt%0d", k), r_igt, (k % 2 == 1));
      if (k > 0) chk($sformatf("rr_drv%0d", k), r_drv, (k % 2 == 1));
      if (k > 0) chk($sformatf("rr_irv%0d", k), r_irv, (k % 2 == 0));
      tick();
    end
    idle_inputs(); mem_rvalid = 1; #1;
    chk("rr_last_irv", r_irv, 1);
    tick(); mem_rvalid = 0; #1;
    chk("rr_idle", r_idle, 1);

    // lock on instruction, then data arrives; round-robin would pick data if unlocked
    do_reset();
    instr_req = 1; #1;
    chk("lk_req", r_req, 1);
    tick(); data_req = 1; data_we = 1; #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lk_addr%0d", k), r_addr, 32'h1000_0040);
      chk($sformatf("lk_we%0d", k), r_we, 0);
      chk($sformatf("lk_idle%0d", k), r_idle, 0);
      tick();
    end
    mem_gnt = 1; #1;
    chk("lk_igt", r_igt, 1);
    chk("lk_dgt", r_dgt, 0);

    // data locked for 3 cycles with instr also requesting
    do_reset();
    instr_req = 1; data_req = 1; data_we = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("ld_addr%0d", k), p_addr, 32'h1000_0100);
      chk($sformatf("ld_we%0d", k), p_we, 1);
      tick();
    end
    mem_gnt = 1; #1;
    chk("ld_dgt", p_dgt, 1);

    // throttle at two outstanding
    do_reset();
    instr_req = 1; mem_gnt = 1;
    tick(); tick(); #1;
    chk("th_full_req", p_req, 0);
    chk("th_full_gnt", p_igt, 0);
    tick(); mem_rvalid = 1; #1;
    chk("th_pop_req", p_req, 0);
    chk("th_pop_irv", p_irv, 1);
    tick(); mem_rvalid = 0; #1;
    chk("th_resume_req", p_req, 1);
    chk("th_resume_gnt", p_igt, 1);
    tick(); #1;
    // two outstanding again; reset discards them
    do_reset(); #1;
    chk("rs_idle", p_idle, 1);
    mem_rvalid = 1; #1;
    chk("rs_no_rvalid", p_irv, 0);

    // spurious rvalid with empty FIFO
    tick(); #1;
    chk("sp_irv", p_irv, 0);
    chk("sp_drv", p_drv, 0);
    chk("sp_idle", p_idle, 1);
    tick(); mem_rvalid = 0; instr_req = 1; mem_gnt = 1; #1;
    chk("sp_gnt", p_igt, 1);
    tick(); instr_req = 0; mem_gnt = 0; mem_rvalid = 1; #1;
    chk("sp_rsp", p_irv, 1);
    tick(); mem_rvalid = 0; #1;
    chk("sp_idle_end", p_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
